// File: rtl/rom_fetch_requester.sv
// Sequential instruction fetcher driving the ROM read port and buffering {pc, instr}
// pairs in a small first-word-fall-through FIFO; a redirect flushes everything in flight.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request pending; waits for a free FIFO slot or a redirect
// REQ   | romIsRequest high at fetchPc, held until the ROM accepts it
// RESP  | ROM data valid this cycle; pushed at the edge unless drop is set

module rom_fetch_requester #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] romAddr,
    output logic        romIsRequest,
    input  logic [31:0] romData,
    input  logic        romRequestDone,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    output logic [31:0] instrData,
    output logic [31:0] instrPc,
    input  logic        instrReady,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [31:0]     fetchPc;
    logic [31:0]     reqPc;
    logic            drop;
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   countNext;
    logic [31:0]     fifoPc   [DEPTH];
    logic [31:0]     fifoData [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic notEmpty;

    assign notEmpty  = (count != '0);
    assign accept    = (state == REQ) && romRequestDone;
    // A redirect on the RESP edge kills the response just like a pending drop.
    assign push      = (state == RESP) && !drop && !redirectValid;
    assign pop       = notEmpty && instrReady && !redirectValid;
    assign countNext = count + CW'(push) - CW'(pop);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (redirectValid || (count < CW'(DEPTH)))
                    nextState = REQ;
            end
            REQ: begin
                if (accept)
                    nextState = RESP;
            end
            RESP: begin
                if (redirectValid || (countNext < CW'(DEPTH)))
                    nextState = REQ;
                else
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqPc   <= '0;
            drop    <= 1'b0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            state <= nextState;
            if (redirectValid) begin
                fetchPc <= redirectPc & ~32'h3;
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
                // An accept on the redirect edge still returns data next cycle; discard it.
                drop    <= accept;
            end else begin
                if (accept) begin
                    reqPc   <= fetchPc;
                    fetchPc <= fetchPc + 32'd4;
                end
                if (state == RESP)
                    drop <= 1'b0;
                if (push)
                    wrPtr <= wrPtr + 1'b1;
                if (pop)
                    rdPtr <= rdPtr + 1'b1;
                count <= countNext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoPc[wrPtr]   <= reqPc;
            fifoData[wrPtr] <= romData;
        end
    end

    assign romIsRequest = (state == REQ);
    assign romAddr      = romIsRequest ? fetchPc : '0;
    assign instrValid   = notEmpty;
    assign instrPc      = notEmpty ? fifoPc[rdPtr] : '0;
    assign instrData    = notEmpty ? fifoData[rdPtr] : '0;
    assign busy         = (state != IDLE) || notEmpty;

endmodule

// File: tb/tb_rom_fetch_requester.sv
// Randomized bench for rom_fetch_requester: a transaction-level fetch model (queue of expected
// {pc, instr} pairs plus the expected next fetch PC) checked every cycle, and directed scenarios.
`timescale 1ns/1ps

module tb_rom_fetch_requester;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] romAddr;
    logic        romIsRequest;
    logic [31:0] romData = '0;
    logic        romRequestDone = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        instrValid;
    logic [31:0] instrData;
    logic [31:0] instrPc;
    logic        instrReady = 1'b0;
    logic        busy;

    rom_fetch_requester #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .romAddr        (romAddr),
        .romIsRequest   (romIsRequest),
        .romData        (romData),
        .romRequestDone (romRequestDone),
        .redirectValid  (redirectValid),
        .redirectPc     (redirectPc),
        .instrValid     (instrValid),
        .instrData      (instrData),
        .instrPc        (instrPc),
        .instrReady     (instrReady),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int asserts = 0;
    int fails   = 0;

    // Model: expected FIFO contents, next fetch PC, and the one response in flight.
    ent_t        q[$];
    logic [31:0] expNextPc;
    bit          pending;
    logic [31:0] pendPc;
    bit          inResp;
    logic [31:0] respAddr;
    int          idleRun;
    int          stepIdx;

    int          acceptCyc[$];
    logic [31:0] acceptAddr[$];
    int          popCyc[$];
    logic [31:0] popPc[$];
    logic [31:0] popData[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, stepIdx);
        end
    endtask

    task automatic modelReset();
        q.delete();
        expNextPc = 32'h0;
        pending   = 1'b0;
        inResp    = 1'b0;
        respAddr  = '0;
        idleRun   = 0;
        stepIdx   = 0;
        acceptCyc.delete();
        acceptAddr.delete();
        popCyc.delete();
        popPc.delete();
        popData.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n          = 1'b0;
        romRequestDone = 1'b0;
        redirectValid  = 1'b0;
        instrReady     = 1'b0;
        #1;
        chk("rst_romIsRequest", romIsRequest, 0);
        chk("rst_romAddr", romAddr, 0);
        chk("rst_instrValid", instrValid, 0);
        chk("rst_instrPc", instrPc, 0);
        chk("rst_instrData", instrData, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic step(input bit ready, input bit done, input bit rv, input logic [31:0] rpc);
        bit   accept;
        bit   popNow;
        ent_t e;
        @(negedge clk);
        romData = inResp ? (respAddr >> 2) : $urandom;

        chk("instrValid", instrValid, q.size() != 0);
        if (q.size() != 0) begin
            chk("instrPc", instrPc, q[0].pc);
            chk("instrData", instrData, q[0].data);
        end
        if (inResp)
            chk("reqDuringResp", romIsRequest, 0);
        if (q.size() == DEPTH)
            chk("reqWhenFull", romIsRequest, 0);
        if (romIsRequest)
            chk("romAddr", romAddr, expNextPc);
        if (q.size() != 0 || inResp || romIsRequest)
            chk("busy", busy, 1);
        if (!romIsRequest && !inResp && q.size() < DEPTH) idleRun++;
        else idleRun = 0;
        if (idleRun > 0)
            chk("idleStall", idleRun > 1, 0);

        instrReady     = ready;
        romRequestDone = done;
        redirectValid  = rv;
        redirectPc     = rpc;

        accept = romIsRequest && done;
        popNow = (q.size() != 0) && ready && !rv;
        if (accept) begin
            acceptCyc.push_back(stepIdx);
            acceptAddr.push_back(romAddr);
        end
        if (popNow) begin
            popCyc.push_back(stepIdx);
            popPc.push_back(q[0].pc);
            popData.push_back(q[0].data);
        end
        if (rv) begin
            q.delete();
            pending   = 1'b0;
            expNextPc = rpc & ~32'h3;
        end else begin
            if (popNow) void'(q.pop_front());
            if (pending) begin
                e.pc   = pendPc;
                e.data = pendPc >> 2;
                q.push_back(e);
            end
            pending = 1'b0;
            if (accept) begin
                pending   = 1'b1;
                pendPc    = expNextPc;
                expNextPc = expNextPc + 32'd4;
            end
        end
        inResp   = accept;
        respAddr = romAddr;
        stepIdx++;
    endtask

    task automatic run(input int n, input bit ready, input bit done);
        for (int i = 0; i < n; i++) step(ready, done, 1'b0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt8;
        logic [31:0] rpc;
        modelReset();

        // 1: streaming, one instruction every two cycles
        doReset();
        run(8, 1'b1, 1'b1);
        chk("t1_acceptCount", acceptAddr.size() >= 3, 1);
        if (acceptAddr.size() >= 3) begin
            chk("t1_acc0", acceptAddr[0], 32'h0);  chk("t1_accCyc0", acceptCyc[0], 1);
            chk("t1_acc1", acceptAddr[1], 32'h4);  chk("t1_accCyc1", acceptCyc[1], 3);
            chk("t1_acc2", acceptAddr[2], 32'h8);  chk("t1_accCyc2", acceptCyc[2], 5);
        end
        chk("t1_popCount", popPc.size() >= 3, 1);
        if (popPc.size() >= 3) begin
            chk("t1_pop0", {popPc[0], popData[0]}, {32'h0, 32'd0}); chk("t1_popCyc0", popCyc[0], 3);
            chk("t1_pop1", popData[1], 32'd1); chk("t1_pop1pc", popPc[1], 32'h4); chk("t1_popCyc1", popCyc[1], 5);
            chk("t1_pop2", popData[2], 32'd2); chk("t1_pop2pc", popPc[2], 32'h8); chk("t1_popCyc2", popCyc[2], 7);
        end

        // 2: consumer stalled, FIFO fills then drains
        doReset();
        run(14, 1'b0, 1'b1);
        chk("t2_acceptCount", acceptAddr.size(), 4);
        chk("t2_reqIdle", romIsRequest, 0);
        if (acceptAddr.size() == 4)
            chk("t2_lastAddr", acceptAddr[3], 32'hC);
        run(12, 1'b1, 1'b1);
        chk("t2_popCount", popPc.size() >= 4, 1);
        if (popPc.size() >= 4) begin
            chk("t2_pop0", popPc[0], 32'h0); chk("t2_pop1", popPc[1], 32'h4);
            chk("t2_pop2", popPc[2], 32'h8); chk("t2_pop3", popPc[3], 32'hC);
            chk("t2_popCyc0", popCyc[0], 14);
        end
        if (acceptAddr.size() >= 5)
            chk("t2_resume", acceptAddr[4], 32'h10);
        else
            chk("t2_resumeMissing", acceptAddr.size(), 5);

        // 3: redirect on the accepting edge drops the in-flight word
        doReset();
        run(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h20);
        run(10, 1'b1, 1'b1);
        cnt8 = 0;
        foreach (popPc[i]) if (popPc[i] == 32'h8) cnt8++;
        chk("t3_noPc8", cnt8, 0);
        chk("t3_popCount", popPc.size() >= 2, 1);
        if (popPc.size() >= 2) begin
            chk("t3_pc", popPc[1], 32'h20); chk("t3_data", popData[1], 32'd8);
            chk("t3_cyc", popCyc[1], 9);
        end
        if (acceptAddr.size() >= 3)
            chk("t3_acc8cyc", acceptCyc[2], 5);

        // 4: misaligned redirect from IDLE
        doReset();
        step(1'b1, 1'b1, 1'b1, 32'h23);
        run(6, 1'b1, 1'b1);
        chk("t4_popCount", popPc.size() >= 1, 1);
        if (acceptAddr.size() >= 1) chk("t4_addr", acceptAddr[0], 32'h20);
        if (popPc.size() >= 1) begin
            chk("t4_pc", popPc[0], 32'h20); chk("t4_data", popData[0], 32'd8);
            chk("t4_cyc", popCyc[0], 3);
        end

        // 5: ROM holds off acceptance
        doReset();
        run(7, 1'b1, 1'b0);
        chk("t5_noAccept", acceptAddr.size(), 0);
        chk("t5_noPop", popPc.size(), 0);
        chk("t5_reqHeld", romIsRequest, 1);
        run(6, 1'b1, 1'b1);
        if (acceptAddr.size() >= 2) begin
            chk("t5_acc0", acceptAddr[0], 32'h0); chk("t5_accCyc0", acceptCyc[0], 7);
            chk("t5_acc1", acceptAddr[1], 32'h4);
        end else chk("t5_acceptCount", acceptAddr.size(), 2);
        if (popPc.size() >= 1) chk("t5_popCyc", popCyc[0], 9);

        // 6: reset asserted while a response is due
        doReset();
        run(2, 1'b0, 1'b1);
        doReset();
        run(6, 1'b1, 1'b1);
        if (popPc.size() >= 1) begin
            chk("t6_popCyc", popCyc[0], 3); chk("t6_pc", popPc[0], 32'h0);
        end else chk("t6_popCount", popPc.size(), 1);

        // Random traffic with redirects, including ones near the top of the address space
        for (int blk = 0; blk < 4; blk++) begin
            doReset();
            for (int i = 0; i < 800; i++) begin
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                                  : ($urandom & 32'h3FF);
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 99) < 5, rpc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
